// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: shares one fifo_sync write port between pSOURCES
// valid/ready producers, tagging each word with its source ID in bursts of up to pBURST.
module fifo_wr_arbiter #(
    parameter int pSOURCES    = 4,
    parameter int pID_WIDTH   = 2,
    parameter int pDATA_WIDTH = 8,
    parameter int pBURST      = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic [pSOURCES-1:0]             src_valid,
    input  logic [pSOURCES*pDATA_WIDTH-1:0] src_data,
    output logic [pSOURCES-1:0]             src_ready,
    input  logic                            fifo_full,
    output logic                            fifo_wen,
    output logic [pID_WIDTH+pDATA_WIDTH-1:0] fifo_wdata,
    output logic                            grant_valid,
    output logic [pID_WIDTH-1:0]            grant_id,
    output logic [31:0]                     word_count
);

    typedef enum logic {
        ST_IDLE,
        ST_GRANTED
    } state_e;

    localparam logic [7:0] BURST_LAST = 8'(pBURST - 1);

    state_e                 state_q, state_d;
    logic [pID_WIDTH-1:0]   grant_id_q, grant_id_d;
    logic [pID_WIDTH-1:0]   last_q, last_d;
    logic [7:0]             bcnt_q, bcnt_d;
    logic [31:0]            word_count_q, word_count_d;

    logic                   granted;
    logic                   sel_valid;
    logic [pDATA_WIDTH-1:0] sel_data;
    logic                   can_accept;
    logic                   accept;
    logic                   release_grant;
    logic                   arb_go;
    logic [pID_WIDTH-1:0]   rr_base;
    logic [pID_WIDTH-1:0]   rr_winner;

    // First requester found scanning base+1, base+2, ... modulo pSOURCES;
    // base itself is visited last, so it only wins when nobody else asks.
    function automatic logic [pID_WIDTH-1:0] rr_pick(
        input logic [pSOURCES-1:0]  req,
        input logic [pID_WIDTH-1:0] base
    );
        logic [pID_WIDTH-1:0] pick;
        logic                 found;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= pSOURCES; k++) begin
            for (int j = 0; j < pSOURCES; j++) begin
                if (!found && req[j] &&
                    ((int'(base) + k == j) || (int'(base) + k == j + pSOURCES))) begin
                    found = 1'b1;
                    pick  = pID_WIDTH'(j);
                end
            end
        end
        return pick;
    endfunction

    assign granted = (state_q == ST_GRANTED);

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int j = 0; j < pSOURCES; j++) begin
            if (grant_id_q == pID_WIDTH'(j)) begin
                sel_valid = src_valid[j];
                sel_data  = src_data[j*pDATA_WIDTH +: pDATA_WIDTH];
            end
        end
    end

    // Ready is also held off while rst_n is low so a word offered in the reset
    // cycle is never handshaken or written.
    assign can_accept = granted & enable & ~fifo_full & rst_n;
    assign accept     = can_accept & sel_valid;

    always_comb begin
        src_ready = '0;
        for (int j = 0; j < pSOURCES; j++) begin
            if (grant_id_q == pID_WIDTH'(j)) begin
                src_ready[j] = can_accept;
            end
        end
    end

    assign fifo_wen   = accept;
    assign fifo_wdata = granted ? {grant_id_q, sel_data} : '0;

    assign arb_go        = enable & (|src_valid);
    assign rr_base       = granted ? grant_id_q : last_q;
    assign rr_winner     = rr_pick(src_valid, rr_base);
    assign release_grant = granted & ((accept & (bcnt_q == BURST_LAST)) | ~sel_valid);

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_d       = last_q;
        bcnt_d       = bcnt_q;
        word_count_d = word_count_q;

        if (accept) begin
            bcnt_d = bcnt_q + 8'd1;
            if (word_count_q != '1) begin
                word_count_d = word_count_q + 32'd1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (arb_go) begin
                    state_d    = ST_GRANTED;
                    grant_id_d = rr_winner;
                    last_d     = rr_winner;
                    bcnt_d     = '0;
                end
            end
            ST_GRANTED: begin
                // Full or disabled only pauses the grant; release needs a burst
                // end or the granted source dropping valid.
                if (release_grant) begin
                    bcnt_d = '0;
                    if (arb_go) begin
                        grant_id_d = rr_winner;
                        last_d     = rr_winner;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples its _d value from before the edge regardless of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= '0;
            last_q       <= pID_WIDTH'(pSOURCES - 1);
            bcnt_q       <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_q       <= last_d;
            bcnt_q       <= bcnt_d;
            word_count_q <= word_count_d;
        end
    end

    assign grant_valid = granted;
    assign grant_id    = grant_id_q;
    assign word_count  = word_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-source stimulus queues, a scoreboard of
// expected FIFO writes checked by a separate monitor, plus cycle-exact grant checks.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [3:0]  src_valid;
    logic [31:0] src_data;
    logic [3:0]  src_ready;
    logic        fifo_full;
    logic        fifo_wen;
    logic [9:0]  fifo_wdata;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [31:0] word_count;

    fifo_wr_arbiter #(
        .pSOURCES   (4),
        .pID_WIDTH  (2),
        .pDATA_WIDTH(8),
        .pBURST     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .fifo_full  (fifo_full),
        .fifo_wen   (fifo_wen),
        .fifo_wdata (fifo_wdata),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sq[4][$];
    logic [9:0] exp_q[$];

    logic       s_wen;
    logic [3:0] s_ready;
    logic       s_gv;
    logic [1:0] s_gid;
    logic [3:0] hs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_srcs();
        for (int s = 0; s < 4; s++) begin
            src_valid[s]       = (sq[s].size() > 0);
            src_data[s*8 +: 8] = (sq[s].size() > 0) ? sq[s][0] : 8'h00;
        end
    endtask

    // Samples one cycle at the falling edge, then retires handshaken words
    // just after the rising edge and presents the next ones.
    task automatic tick();
        logic [7:0] dummy;
        @(negedge clk);
        s_wen   = fifo_wen;
        s_ready = src_ready;
        s_gv    = grant_valid;
        s_gid   = grant_id;
        hs      = src_valid & src_ready;
        @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            if (hs[s]) dummy = sq[s].pop_front();
        end
        drive_srcs();
    endtask

    task automatic push_src(input int s, input logic [7:0] d);
        sq[s].push_back(d);
    endtask

    task automatic push_exp(input int s, input logic [7:0] d);
        exp_q.push_back({2'(s), d});
    endtask

    // Scoreboard monitor: every FIFO write must match the next expected entry.
    always @(negedge clk) begin
        if (fifo_full) check("no_wen_when_full", 64'(fifo_wen), 64'd0);
        if (fifo_wen) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wen", 64'(fifo_wen), 64'd0);
            end else begin
                check("fifo_wdata", 64'(fifo_wdata), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        enable    = 1'b0;
        fifo_full = 1'b0;
        src_valid = '0;
        src_data  = '0;

        // Reset state
        tick();
        tick();
        check("rst_grant_valid", 64'(grant_valid), 64'd0);
        check("rst_grant_id",    64'(grant_id),    64'd0);
        check("rst_word_count",  64'(word_count),  64'd0);
        check("rst_src_ready",   64'(src_ready),   64'd0);
        check("rst_fifo_wen",    64'(fifo_wen),    64'd0);
        check("rst_fifo_wdata",  64'(fifo_wdata),  64'd0);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Single source 1 streaming 0x10..0x17: two back-to-back bursts of 4
        for (int k = 0; k < 8; k++) begin
            push_src(1, 8'(8'h10 + k));
            push_exp(1, 8'(8'h10 + k));
        end
        drive_srcs();
        tick();
        check("t1_idle_cycle_wen",   64'(s_wen),   64'd0);
        check("t1_idle_cycle_ready", 64'(s_ready), 64'd0);
        tick();
        check("t1_latency_ready", 64'(s_ready), 64'b0010);
        check("t1_latency_gid",   64'(s_gid),   64'd1);
        n = int'(s_wen);
        for (int i = 0; i < 7; i++) begin
            tick();
            n += int'(s_wen);
        end
        check("t1_writes_no_bubble", 64'(n), 64'd8);
        tick();
        tick();
        check("t1_idle_after", 64'(grant_valid), 64'd0);
        check("t1_word_count", 64'(word_count),  64'd8);

        // Reset so source 0 leads the rotation, then all four sources compete
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t2_wc_after_reset", 64'(word_count), 64'd0);
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 8; k++) push_src(s, 8'(s*16 + k));
        end
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 4; s++) begin
                for (int k = 0; k < 4; k++) push_exp(s, 8'(s*16 + r*4 + k));
            end
        end
        drive_srcs();
        tick();
        check("t2_idle_cycle_wen", 64'(s_wen), 64'd0);
        n = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            n += int'(s_wen);
        end
        check("t2_writes_no_gap", 64'(n), 64'd32);
        tick();
        tick();
        check("t2_idle_after", 64'(grant_valid), 64'd0);
        check("t2_word_count", 64'(word_count),  64'd32);

        // Full backpressure mid-burst on source 0; source 1 waits for the rotation
        for (int k = 0; k < 6; k++) push_src(0, 8'(8'h50 + k));
        push_src(1, 8'h60);
        for (int k = 0; k < 4; k++) push_exp(0, 8'(8'h50 + k));
        push_exp(1, 8'h60);
        push_exp(0, 8'h54);
        push_exp(0, 8'h55);
        drive_srcs();
        tick();
        tick();
        tick();
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_full_wen",   64'(s_wen),   64'd0);
            check("t3_full_ready", 64'(s_ready), 64'd0);
            check("t3_full_gv",    64'(s_gv),    64'd1);
            check("t3_full_gid",   64'(s_gid),   64'd0);
        end
        fifo_full = 1'b0;
        tick();
        check("t3_resume_wen", 64'(s_wen), 64'd1);
        for (int i = 0; i < 6; i++) tick();
        check("t3_idle_after", 64'(grant_valid), 64'd0);
        check("t3_word_count", 64'(word_count),  64'd39);

        // Early release: source 2 runs dry after 2 words while source 3 waits
        push_src(2, 8'h70);
        push_src(2, 8'h71);
        for (int k = 0; k < 3; k++) push_src(3, 8'(8'h80 + k));
        push_exp(2, 8'h70);
        push_exp(2, 8'h71);
        for (int k = 0; k < 3; k++) push_exp(3, 8'(8'h80 + k));
        drive_srcs();
        tick();
        tick();
        tick();
        tick();
        check("t4_drop_gid", 64'(s_gid), 64'd2);
        check("t4_drop_wen", 64'(s_wen), 64'd0);
        tick();
        check("t4_handover_gid",   64'(s_gid),   64'd3);
        check("t4_handover_wen",   64'(s_wen),   64'd1);
        check("t4_handover_ready", 64'(s_ready), 64'b1000);
        tick();
        tick();
        tick();
        check("t4_idle_after", 64'(grant_valid), 64'd0);
        check("t4_word_count", 64'(word_count),  64'd44);

        // Enable pause, then reset mid-burst on source 1
        for (int k = 0; k < 8; k++) push_src(1, 8'(8'h90 + k));
        for (int k = 0; k < 3; k++) push_exp(1, 8'(8'h90 + k));
        drive_srcs();
        tick();
        tick();
        tick();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_disabled_wen", 64'(s_wen), 64'd0);
            check("t5_disabled_gv",  64'(s_gv),  64'd1);
            check("t5_disabled_gid", 64'(s_gid), 64'd1);
        end
        enable = 1'b1;
        tick();
        check("t5_resume_wen", 64'(s_wen), 64'd1);
        rst_n = 1'b0;
        push_src(0, 8'hA0);
        push_exp(0, 8'hA0);
        for (int k = 3; k < 8; k++) push_exp(1, 8'(8'h90 + k));
        drive_srcs();
        tick();
        check("t5_reset_cycle_wen", 64'(s_wen), 64'd0);
        check("t5_post_rst_gv",  64'(grant_valid), 64'd0);
        check("t5_post_rst_wc",  64'(word_count),  64'd0);
        check("t5_post_rst_gid", 64'(grant_id),    64'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("t5_first_gid", 64'(s_gid), 64'd0);
        check("t5_first_wen", 64'(s_wen), 64'd1);
        for (int i = 0; i < 7; i++) tick();
        check("t5_idle_after", 64'(grant_valid), 64'd0);
        check("t5_word_count", 64'(word_count),  64'd6);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `fifo_sync` write port between `pSOURCES` independent producers (capture engines, trigger timestamp units, register-side injectors). Each producer uses a valid/ready handshake. The arbiter grants one source at a time for bursts of up to `pBURST` words and tags each word with the source ID before writing it to the FIFO. It sits directly upstream of `fifo_sync`, drives `wen`/`wdata`, and obeys `full` so the FIFO never overflows.

## Interface
Parameters:
- `pSOURCES`, 4: number of requesters, 2..8.
- `pID_WIDTH`, 2: source tag width; must satisfy 2^`pID_WIDTH` >= `pSOURCES`.
- `pDATA_WIDTH`, 8: payload width per source.
- `pBURST`, 4: maximum words accepted per grant before rotating, 1..256.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset; synchronous, active-low.
- `enable`  in  1  arbitration enable; when low, no word is accepted.
- `src_valid`  in  `pSOURCES`  per-source word available.
- `src_data`  in  `pSOURCES*pDATA_WIDTH`  source i occupies bits [i*pDATA_WIDTH +: pDATA_WIDTH].
- `src_ready`  out  `pSOURCES`  per-source accept; a transfer occurs when valid and ready are both high at a rising edge.
- `fifo_full`  in  1  from `fifo_sync.full`.
- `fifo_wen`  out  1  to `fifo_sync.wen`.
- `fifo_wdata`  out  `pID_WIDTH+pDATA_WIDTH`  {grant_id, data}; to `fifo_sync.wdata`.
- `grant_valid`  out  1  a source currently holds the grant.
- `grant_id`  out  `pID_WIDTH`  index of the granted source.
- `word_count`  out  32  total words written since reset; saturates at 0xFFFFFFFF.

## Operation
- States: IDLE (no grant) and GRANTED (grant_id = g, burst counter `bcnt`, 8 bits).
- Round-robin pointer `last` holds the most recently granted source. Reset value is `pSOURCES-1`, so source 0 has first priority.
- **IDLE:** if `enable` is high and any `src_valid` bit is set, select the first valid source scanning `last+1`, `last+2`, … with wrap modulo `pSOURCES`. Register that source as `grant_id`, set `last` to it, clear `bcnt`, and enter GRANTED. Otherwise remain in IDLE.
- **GRANTED:**
  - Combinational outputs:
    - `src_ready[g]` = `enable & ~fifo_full`; all other `src_ready` bits are 0.
    - `fifo_wen` = `src_valid[g] & src_ready[g]`.
    - `fifo_wdata` = {g, src_data[g]}.
  - On each accepted word, `bcnt` increments and `word_count` increments (saturating).
  - **Release conditions:** (a) the accepted word is the `pBURST`-th of the grant; (b) `src_valid[g]` is low, regardless of `fifo_full` or `enable`.
  - **On release:** if `enable` is high and any source is valid, re-arbitrate in the same cycle starting from `g+1`, with no bubble. Source g may win again only if it is the only requester. Otherwise go to IDLE.
- `fifo_full` high while granted: no accept, `bcnt` holds, the grant holds, and no rotation occurs.
- `enable` low while granted: the grant is held and no accept occurs. This pauses the current grant; it does not release it.
- In IDLE, `fifo_wdata` = 0, `fifo_wen` = 0 and `src_ready` = 0.
- `fifo_wen` is never asserted while `fifo_full` is high, so `fifo_sync.overflow` must never fire.

## Timing
- Reset (`rst_n` low at a rising edge) forces the following regardless of state:
  - state IDLE, `grant_valid` 0, `grant_id` 0, `last` `pSOURCES-1`, `bcnt` 0, `word_count` 0.
  - Hence `src_ready` 0, `fifo_wen` 0, `fifo_wdata` 0.
  - A word offered in the reset cycle is not accepted.
- **Grant latency:** a source that raises valid in cycle N while the arbiter is IDLE sees `src_ready` high in cycle N+1, provided the FIFO is not full. The first transfer occurs at the end of cycle N+1.
- **Throughput:** within a grant, one word per cycle. Handover between back-to-back requesters costs 0 cycles.
- `fifo_wen`/`fifo_wdata` are combinational from the registered grant and the current valid/data. The FIFO write occurs at the same edge as the handshake.
- `word_count` reflects a write one cycle after the `fifo_wen` edge.

## Test plan
- **Single source, pBURST=4:** source 1 streams 0x10..0x17 continuously. Required: grant held for 4 words, a release/re-grant to source 1 with no bubble, and 8 FIFO entries {1, 0x10}..{1, 0x17}, `word_count` 8.
- **All four sources valid continuously:** required grant order 0,1,2,3,0,…; each grant writes exactly 4 words; 0 idle cycles between grants.
- **Full backpressure:** hold `fifo_full` high for 5 cycles mid-burst. Required: `fifo_wen` 0 and `src_ready` 0 for those 5 cycles, `bcnt` frozen, the grant unchanged, and the remaining burst words written after `fifo_full` drops. FIFO `overflow` never asserts.
- **Early release:** source 2 drops valid after 2 words while source 3 is waiting. Required: grant moves to 3 in the same cycle; source 3's first word is written the next edge.
- **Enable and reset mid-burst:** deassert `enable` for 3 cycles. Required: no writes and the grant held. Then assert `rst_n`=0 for 1 cycle mid-burst. Required: `grant_valid` 0 and `word_count` 0 the next cycle, and source 0 is served first afterwards.
